// File: rtl/alu_operand_stage.sv
// alu_operand_stage
// Operand-fetch stage for a small ALU: an NREG-entry register file (R0 hard-wired to zero),
// immediate extension for operand B, and the carry/zero flag register.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   rs_addr, rt_addr         read addresses for op_a and op_b/rt_data
//   rd_addr, wr_en, wr_data  write-back port (ALU result)
//   use_imm, imm, imm_sext   operand B immediate select and extension control
//   flag_we, carry_d, zero_d flag register update
//   op_a, op_b, rt_data      combinational operand reads of pre-edge state
//   carry_q, zero_q          stored flags
module alu_operand_stage #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned NREG   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [$clog2(NREG)-1:0] rs_addr,
  input  logic [$clog2(NREG)-1:0] rt_addr,
  input  logic [$clog2(NREG)-1:0] rd_addr,
  input  logic                    wr_en,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    use_imm,
  input  logic [4:0]              imm,
  input  logic                    imm_sext,
  input  logic                    flag_we,
  input  logic                    carry_d,
  input  logic                    zero_d,
  output logic [DATA_W-1:0]       op_a,
  output logic [DATA_W-1:0]       op_b,
  output logic [DATA_W-1:0]       rt_data,
  output logic                    carry_q,
  output logic                    zero_q
);

  localparam int unsigned AddrW = $clog2(NREG);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] imm_ext;

  // Entry 0 is reset and never written; reads of address 0 are also forced to zero so R0
  // reads as zero even before the first reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      if (wr_en && (rd_addr != '0)) begin
        regs_q[rd_addr] <= wr_data;
      end
      if (flag_we) begin
        carry_q <= carry_d;
        zero_q  <= zero_d;
      end
    end
  end

  // Reads see pre-edge contents only; a write-to-read bypass would close a loop through the ALU.
  always_comb begin
    op_a    = (rs_addr == AddrW'(0)) ? '0 : regs_q[rs_addr];
    rt_data = (rt_addr == AddrW'(0)) ? '0 : regs_q[rt_addr];
  end

  // Zero extension is used for shift amounts, sign extension for arithmetic immediates.
  always_comb begin
    if (imm_sext) begin
      imm_ext = {{(DATA_W-5){imm[4]}}, imm};
    end else begin
      imm_ext = {{(DATA_W-5){1'b0}}, imm};
    end
    op_b = use_imm ? imm_ext : rt_data;
  end

endmodule

// File: doc/alu_operand_stage.md
ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, the datapath and register width.
REQ-002 The block SHALL have parameter NREG, default 8, the number of general registers (address width 3).
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, synchronous active-high reset, sampled on rising clk.
REQ-005 Port rs_addr, input, 3, register selected for op_a.
REQ-006 Port rt_addr, input, 3, register selected for op_b (when use_imm=0) and rt_data.
REQ-007 Port rd_addr, input, 3, write-back destination register.
REQ-008 Port wr_en, input, 1, write-back enable.
REQ-009 Port wr_data, input, 8, write-back value (ALU result R).
REQ-010 Port use_imm, input, 1, 1 = op_b from immediate, 0 = op_b from register.
REQ-011 Port imm, input, 5, immediate field.
REQ-012 Port imm_sext, input, 1, 1 = sign-extend imm, 0 = zero-extend (shift amounts).
REQ-013 Port flag_we, input, 1, flag register update enable.
REQ-014 Port carry_d, input, 1, next carry flag (ALU carry_out).
REQ-015 Port zero_d, input, 1, next zero flag (ALU zero).
REQ-016 Port op_a, output, 8, ALU operand A.
REQ-017 Port op_b, output, 8, ALU operand B.
REQ-018 Port rt_data, output, 8, raw contents of register rt_addr regardless of use_imm.
REQ-019 Port carry_q, output, 1, stored carry flag, drives ALU carry_in.
REQ-020 Port zero_q, output, 1, stored zero flag.

Function
REQ-021 Registers R1..R7 SHALL each hold 8 bits; R0 SHALL always read 8'h00 and ignore writes.
REQ-022 op_a, rt_data and register-sourced op_b SHALL be combinational reads of the current (pre-edge) register contents; no write-to-read bypass (avoids combinational loop through the ALU).
REQ-023 When wr_en=1 and rd_addr!=0, register rd_addr SHALL take wr_data at the rising clk edge; wr_en=0 leaves all registers unchanged.
REQ-024 Reading and writing the same register in one cycle SHALL return the old value that cycle and the new value from the next cycle.
REQ-025 With use_imm=1, imm_sext=1: op_b = {3{imm[4]}, imm}; imm_sext=0: op_b = {3'b000, imm}.
REQ-026 With use_imm=0, op_b SHALL equal register rt_addr; imm and imm_sext ignored.
REQ-027 When flag_we=1, carry_q and zero_q SHALL load carry_d and zero_d at the rising edge; otherwise they hold.
REQ-028 Flag update and register write in the same cycle SHALL both take effect independently.
REQ-029 Register and flag writes SHALL have one-cycle latency; outputs reflect them in the cycle after the edge.
REQ-030 No internal state machine beyond storage; all outputs purely function of stored state and current address/control inputs.

Reset
REQ-031 When rst=1 at a rising edge, R1..R7, carry_q and zero_q SHALL clear to 0, overriding wr_en and flag_we in that cycle.
REQ-032 After reset, op_a=op_b=rt_data=8'h00 for any register address with use_imm=0.
REQ-033 Reset asserted mid-sequence SHALL discard any write presented in that cycle; no partial state remains.

Verification
REQ-034 Write 8'hA5 to R3, then rs_addr=3 -> op_a=8'hA5 next cycle; same cycle op_a=old value (8'h00 after reset).
REQ-035 wr_en=1, rd_addr=0, wr_data=8'hFF; then rs_addr=0 -> op_a=8'h00.
REQ-036 use_imm=1, imm=5'b10110: imm_sext=1 -> op_b=8'hF6; imm_sext=0 -> op_b=8'h16; rt_data unchanged from register rt_addr.
REQ-037 flag_we=1, carry_d=1, zero_d=0 -> carry_q=1, zero_q=0 next cycle; flag_we=0, carry_d=0 -> carry_q stays 1.
REQ-038 Fill R1..R7 with 8'h11..8'h77, assert rst with wr_en=1 rd_addr=2 wr_data=8'hEE -> all registers and flags 0, R2 not 8'hEE.
REQ-039 Same-cycle write R4=8'h3C and flag_we=1 carry_d=1 -> next cycle op_a (rs_addr=4)=8'h3C and carry_q=1.
